scale_mult_seq: RTL and testbench
=================================

// Module: scale_mult_seq
// PURPOSE
//   Sequential unsigned scaler: result = a * k, with a runtime factor k.
//   It is the parametrised successor of the fixed x3 combinational scaler.
//   It uses an LSB-first shift-and-add datapath with valid/ready handshakes on input and output.
//   An optional saturating output narrows the result for downstream fixed-width consumers.
// PARAMETERS
//   DATA_W    4  width of operand a (unsigned)
//   FACTOR_W  2  width of factor k (unsigned); also the number of BUSY cycles
//   OUT_W     6  result width; full product width P = DATA_W+FACTOR_W (localparam)
// PORTS
//   clk         in   1         single clock, all logic on rising edge
//   rst_n       in   1         synchronous, active-low reset
//   in_valid    in   1         a/k valid
//   in_ready    out  1         block can accept a/k
//   in_a        in   DATA_W    operand
//   in_k        in   FACTOR_W  multiplication factor
//   out_valid   out  1         result valid
//   out_ready   in   1         consumer accepts result
//   out_result  out  OUT_W     product, zero-extended or saturated
//   out_ovf     out  1         1 = product exceeded 2^OUT_W-1 and was saturated
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low (clk, rst_n).
//   - Reset (rst_n=0 at an edge) sets the following:
//       state=IDLE, out_valid=0, out_result=0, out_ovf=0, accumulator=0, bit counter=0.
//     in_ready=0 while rst_n=0.
//   - Reset has priority over everything.
//     Reset mid-operation aborts the operation and discards the operand; no output is produced.
//   - FSM IDLE:
//       in_ready=1.
//       On in_valid&&in_ready: latch a and k, clear the accumulator and counter, go to BUSY.
//   - FSM BUSY:
//       in_ready=0.
//       Each edge: if k[cnt]=1 then acc += a<<cnt; cnt++.
//       After exactly FACTOR_W BUSY edges, go to DONE; out_result/out_ovf are registered on that edge.
//       There is no early exit; k=0 takes the same latency.
//   - FSM DONE:
//       out_valid=1, in_ready=0.
//       out_result and out_ovf are held stable until out_valid&&out_ready.
//       On that edge: out_valid=0, go to IDLE.
//   - Latency: out_valid rises FACTOR_W edges after the accepting edge.
//     Minimum spacing between accepts is FACTOR_W+2 edges (no overlap of operations).
//   - in_valid during BUSY/DONE is ignored; the upstream must hold it until in_ready.
//   - The accumulator is P bits wide and never overflows internally.
//   - Width rule:
//       OUT_W >= P: out_result = zero-extended product, out_ovf=0.
//       OUT_W <  P: if product > 2^OUT_W-1, out_result = all ones and out_ovf=1;
//                   otherwise out_result = product[OUT_W-1:0] and out_ovf=0.
//   - out_result keeps its last value after the handshake; it is only meaningful while out_valid=1.
// TESTING
//   1. rst_n=0 for 3 edges with in_valid=1, a=5, k=3
//      -> in_ready=0, out_valid=0, out_result=0 throughout; in_ready=1 after release.
//   2. Defaults, k=3, a in {0,1,3,5,10,15}, out_ready=1
//      -> results 0,3,9,15,30,45, out_ovf=0, out_valid exactly 2 edges after accept.
//   3. a=15, k=3, out_ready=0 for 5 cycles, in_valid=1 with a=1
//      -> out_valid stays 1, result 45 stable, in_ready=0, second operand not taken until handshake.
//   4. OUT_W=5: a=15, k=3 -> out_result=31, out_ovf=1; a=10, k=3 -> 30, out_ovf=0.
//   5. Accept a=5, k=3; rst_n=0 one edge later
//      -> out_valid never rises; then a=1, k=2 -> result 2 after 2 edges.
//   6. DATA_W=8, FACTOR_W=4, OUT_W=12: a=255, k=15 -> 3825 after 4 edges;
//      back-to-back with out_ready=1 and k=0 -> result 0, one result per 6 edges.

Source files
------------

// File: rtl/scale_mult_seq.sv
//------------------------------------------------------------------------------
// Module   : scale_mult_seq
// Purpose  : Sequential unsigned scaler, result = a * k. It uses an LSB-first
//            shift-and-add datapath with valid/ready handshakes on both sides,
//            and an optional saturating narrow output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scale_mult_seq #(
  parameter int DATA_W   = 4,
  parameter int FACTOR_W = 2,
  parameter int OUT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [FACTOR_W-1:0] in_k,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_result,
  output logic                out_ovf
);

  // Full product width; the accumulator never needs more than this.
  localparam int P     = DATA_W + FACTOR_W;
  localparam int CNT_W = (FACTOR_W > 1) ? $clog2(FACTOR_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACTOR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_W-1:0]     a_q;
  logic [FACTOR_W-1:0]   k_q;
  logic [P-1:0]          acc_q;
  logic [P-1:0]          acc_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  out_valid_q;
  logic [OUT_W-1:0]      out_result_q;
  logic                  out_ovf_q;
  logic [OUT_W-1:0]      result_d;
  logic                  ovf_d;

  // Next accumulator value: add the shifted operand when the current factor bit is set.
  always_comb begin
    acc_d = acc_q;
    if (k_q[cnt_q]) begin
      acc_d = acc_q + (P'(a_q) << cnt_q);
    end
  end

  // Output width adaptation of the final product (zero-extend or saturate).
  generate
    if (OUT_W >= P) begin : g_zext
      assign result_d = OUT_W'(acc_d);
      assign ovf_d    = 1'b0;
    end else begin : g_sat
      assign ovf_d    = |acc_d[P-1:OUT_W];
      assign result_d = ovf_d ? {OUT_W{1'b1}} : acc_d[OUT_W-1:0];
    end
  endgenerate

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            k_q     <= in_k;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Final factor bit: publish the result on this same edge.
          if (cnt_q == CNT_LAST) begin
            state_q      <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= result_d;
            out_ovf_q    <= ovf_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so upstream never sees a false accept window.
  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_scale_mult_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_scale_mult_seq
// Purpose  : Directed self-checking bench for scale_mult_seq with three
//            parameter sets (default, narrow saturating, wide).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_scale_mult_seq;

  logic clk;
  logic rst_n;

  logic       iv   [3];
  logic       ordy [3];
  logic [7:0] ia   [3];
  logic [3:0] ik   [3];
  logic       irdy [3];
  logic       ov   [3];
  logic       ovf  [3];
  logic [5:0]  res0;
  logic [4:0]  res1;
  logic [11:0] res2;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Default parameters: 4x2 -> 6
  scale_mult_seq u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_a(ia[0][3:0]), .in_k(ik[0][1:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_result(res0), .out_ovf(ovf[0])
  );

  // Narrow output: 4x2 -> 5, saturating
  scale_mult_seq #(.DATA_W(4), .FACTOR_W(2), .OUT_W(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_a(ia[1][3:0]), .in_k(ik[1][1:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_result(res1), .out_ovf(ovf[1])
  );

  // Wide: 8x4 -> 12
  scale_mult_seq #(.DATA_W(8), .FACTOR_W(4), .OUT_W(12)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(irdy[2]), .in_a(ia[2]), .in_k(ik[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_result(res2), .out_ovf(ovf[2])
  );

  function automatic logic [11:0] get_res(input int i);
    case (i)
      0:       return {6'd0, res0};
      1:       return {7'd0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic int fw(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: wait for ready, accept, check latency and result,
  // and complete the handshake when out_ready is high.
  task automatic do_op(input int i, input logic [7:0] a, input logic [3:0] k,
                       input logic [11:0] exp_res, input logic exp_ovf,
                       input string tag, output int acc_cycle);
    int n;
    n = 0;
    while (!irdy[i] && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " in_ready"}, 32'(irdy[i]), 32'd1);
    ia[i] = a;
    ik[i] = k;
    iv[i] = 1'b1;
    tick();
    acc_cycle = cycle;
    iv[i] = 1'b0;
    chk({tag, " busy in_ready"}, 32'(irdy[i]), 32'd0);
    for (int c = 1; c <= fw(i); c++) begin
      if (c > 1) chk({tag, " early out_valid"}, 32'(ov[i]), 32'd0);
      if (c < fw(i)) tick();
    end
    chk({tag, " busy out_valid"}, 32'(ov[i]), 32'd0);
    tick();
    chk({tag, " out_valid"}, 32'(ov[i]), 32'd1);
    chk({tag, " result"}, 32'(get_res(i)), 32'(exp_res));
    chk({tag, " ovf"}, 32'(ovf[i]), 32'(exp_ovf));
    if (ordy[i]) begin
      tick();
      chk({tag, " out_valid after hs"}, 32'(ov[i]), 32'd0);
    end
  endtask

  initial begin : main
    int t0;
    int t1;
    int av [6];
    av = '{0, 1, 3, 5, 10, 15};

    // Test 1: reset held for 3 edges with a pending request
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b1; ia[i] = 8'd5; ik[i] = 4'd3; ordy[i] = 1'b1;
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("rst in_ready", 32'(irdy[0]), 32'd0);
      chk("rst out_valid", 32'(ov[0]), 32'd0);
      chk("rst out_result", 32'(res0), 32'd0);
    end
    chk("rst ovf", 32'(ovf[0]), 32'd0);
    chk("rst wide result", 32'(res2), 32'd0);
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release in_ready", 32'(irdy[0]), 32'd1);

    // Test 2: defaults, k=3
    for (int j = 0; j < 6; j++) begin
      do_op(0, 8'(av[j]), 4'd3, 12'(av[j] * 3), 1'b0, $sformatf("x3 a=%0d", av[j]), t0);
    end

    // Test 3: stalled consumer holds result; new request waits
    ordy[0] = 1'b0;
    do_op(0, 8'd15, 4'd3, 12'd45, 1'b0, "stall", t0);
    ia[0] = 8'd1;
    iv[0] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("stall out_valid", 32'(ov[0]), 32'd1);
      chk("stall result", 32'(res0), 32'd45);
      chk("stall in_ready", 32'(irdy[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    tick();
    chk("stall hs out_valid", 32'(ov[0]), 32'd0);
    chk("stall hs in_ready", 32'(irdy[0]), 32'd1);
    tick();
    iv[0] = 1'b0;
    tick();
    chk("second early out_valid", 32'(ov[0]), 32'd0);
    tick();
    chk("second out_valid", 32'(ov[0]), 32'd1);
    chk("second result", 32'(res0), 32'd3);
    tick();

    // Test 4: narrow saturating output
    do_op(1, 8'd15, 4'd3, 12'd31, 1'b1, "sat 15x3", t0);
    do_op(1, 8'd10, 4'd3, 12'd30, 1'b0, "sat 10x3", t0);
    do_op(1, 8'd15, 4'd2, 12'd30, 1'b0, "sat 15x2", t0);

    // Test 5: reset one edge after accept aborts the operation
    ia[0] = 8'd5; ik[0] = 4'd3; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("abort out_valid", 32'(ov[0]), 32'd0);
    end
    do_op(0, 8'd1, 4'd2, 12'd2, 1'b0, "after abort", t0);

    // Test 6: wide instance, back-to-back spacing
    do_op(2, 8'd255, 4'd15, 12'd3825, 1'b0, "wide 255x15", t0);
    do_op(2, 8'd255, 4'd0, 12'd0, 1'b0, "wide k=0", t1);
    chk("wide accept spacing", 32'(t1 - t0), 32'd6);
    do_op(2, 8'd200, 4'd9, 12'd1800, 1'b0, "wide 200x9", t0);
    chk("wide accept spacing 2", 32'(t0 - t1), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
